// File: rtl/test_image_generator_pkg.sv
// Shared definitions for the synthetic image stream generator.
// Holds the FSM state encoding, checksum constants and byte-swap helpers.
// Imported by the generator top and its Fletcher-32 accumulator.
package test_image_generator_pkg;

    // FSM state encoding (plain constants so legacy tools see a fixed width)
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StHeader = 3'd1;
    localparam logic [2:0] StPixel  = 3'd2;
    localparam logic [2:0] StCksA   = 3'd3;
    localparam logic [2:0] StCksB   = 3'd4;
    localparam logic [2:0] StPad    = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

    // Two 16-bit words carry the 32-bit Fletcher checksum
    localparam int ChecksumWordCount = 2;

    // Fletcher-32 modulus, 17 bits wide to compare against a 17-bit partial sum
    localparam logic [16:0] FletcherModulus = 17'd65535;

    // Host values are little-endian on the wire: swap bytes within the word
    function automatic logic [15:0] byteSwap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    // Full 32-bit swap: [31:16] is the first wire word, [15:0] the second
    function automatic logic [31:0] byteSwap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/test_image_generator_if.sv
// Output word stream of the test image generator (valid/ready handshake).
// Ports: dout (16-bit wire word), dout_valid, dout_ready.
// master = generator side, slave = SD/RAM write path side.
interface test_image_generator_if;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/test_image_generator_fletcher32_accum.sv
// Fletcher-32 running sums over 16-bit host values.
// Latency: one cycle per accepted word; dout is the registered {s2, s1}.
// Backpressure: none; the caller pulses en once per word. clr+en restarts from the new word.
// Ports: clk, rst (sync, active high), clr, en, din[15:0], dout[31:0].
module test_image_generator_fletcher32_accum
    import test_image_generator_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] dout
);

    logic [15:0] s1, s2;
    logic [15:0] base1, base2, next1, next2;
    logic [16:0] sum1, sum2;

    // Each mod-65535 step: 17-bit add, then one conditional subtract. Both
    // operands are below 65536 and the running sum is below 65535, so a
    // single subtract always lands back in range.
    always_comb begin
        base1 = clr ? 16'd0 : s1;
        base2 = clr ? 16'd0 : s2;
        sum1  = {1'b0, base1} + {1'b0, din};
        next1 = (sum1 >= FletcherModulus) ? 16'(sum1 - FletcherModulus) : sum1[15:0];
        sum2  = {1'b0, base2} + {1'b0, next1};
        next2 = (sum2 >= FletcherModulus) ? 16'(sum2 - FletcherModulus) : sum2[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else if (en) begin
            s1 <= next1;
            s2 <= next2;
        end else if (clr) begin
            s1 <= '0;
            s2 <= '0;
        end
    end

    assign dout = {s2, s1};

endmodule

// File: rtl/test_image_generator.sv
// Synthetic image word source: header words, W*H pixels, Fletcher-32 checksum, zero padding.
// Latency: first word valid the cycle after start; then one word per accepted transfer, no bubbles.
// Backpressure: dout/dout_valid hold while dout_ready is low; all outputs registered.
// Ports: clk, rst (sync, active high), start, image_width/height, pixel_initial/delta (latched on
// start), header_idx/header_word (caller's combinational header lookup), stream (dout handshake),
// busy, done. Optional macro TEST_IMAGE_GENERATOR_ERRINJ_EN adds err_inject (flips bit 0 of CksA).
module test_image_generator
    import test_image_generator_pkg::*;
#(
    parameter int HeaderWordCount  = 5,
    parameter int PaddingWordCount = 0,
    parameter int DimWidth         = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DimWidth-1:0]    image_width,
    input  logic [DimWidth-1:0]    image_height,
    input  logic [15:0]            pixel_initial,
    input  logic [15:0]            pixel_delta,
`ifdef TEST_IMAGE_GENERATOR_ERRINJ_EN
    input  logic                   err_inject,
`endif
    output logic [7:0]             header_idx,
    input  logic [15:0]            header_word,
    test_image_generator_if.master stream,
    output logic                   busy,
    output logic                   done
);

    localparam int          PixW      = 2 * DimWidth;
    localparam logic [7:0]  HdrCount  = 8'(HeaderWordCount);
    localparam logic [15:0] PadLast   = 16'(PaddingWordCount - 1);
    localparam bit          HasHeader = (HeaderWordCount != 0);
    localparam bit          HasPad    = (PaddingWordCount != 0);

    logic [2:0]      state, nextState, enterState;
    logic [15:0]     doutQ, nextWord, accDin;
    logic            doutValidQ, xfer, leave, loadNow, accEn, idle;
    logic [15:0]     pixVal, pixNext, pixInitQ, pixDeltaQ, curInit;
    logic [PixW-1:0] pixCnt, pixTotalQ;
    logic [15:0]     padCnt;
    logic [31:0]     sum, curSum, sumSwapped;
    logic            curPixNonEmpty, curErr;

    assign idle    = (state == StIdle);
    assign xfer    = doutValidQ && stream.dout_ready;
    assign pixNext = pixVal + pixDeltaQ;

    // In Idle the config inputs are not latched yet and the sums are stale,
    // so the first word is built from the live inputs and an empty checksum.
    assign curInit        = idle ? pixel_initial : pixInitQ;
    assign curSum         = idle ? 32'd0 : sum;
    assign curPixNonEmpty = idle ? ((image_width != '0) && (image_height != '0))
                                 : (pixTotalQ != '0);
    assign sumSwapped     = byteSwap32(curSum);

`ifdef TEST_IMAGE_GENERATOR_ERRINJ_EN
    logic errInjQ;
    assign curErr = idle ? err_inject : errInjQ;
    always_ff @(posedge clk) begin
        if (rst)
            errInjQ <= 1'b0;
        else if (idle && start)
            errInjQ <= err_inject;
    end
`else
    assign curErr = 1'b0;
`endif

    // Next word is prepared when the current one transfers. Words are added
    // to the checksum when loaded into dout rather than when they leave; every
    // loaded word is transferred before the checksum words, so the sums are
    // complete by the time CksA is loaded.
    always_comb begin
        leave      = 1'b0;
        enterState = state;
        nextState  = state;
        loadNow    = 1'b0;
        nextWord   = doutQ;
        accEn      = 1'b0;
        accDin     = '0;
        case (state)
            StIdle: if (start) begin
                leave      = 1'b1;
                enterState = HasHeader ? StHeader : (curPixNonEmpty ? StPixel : StCksA);
            end
            StHeader: if (xfer) begin
                // header_idx already points one past the word on dout
                if (header_idx == HdrCount) begin
                    leave      = 1'b1;
                    enterState = curPixNonEmpty ? StPixel : StCksA;
                end else begin
                    loadNow  = 1'b1;
                    nextWord = header_word;
                    accEn    = 1'b1;
                    accDin   = byteSwap16(header_word);
                end
            end
            StPixel: if (xfer) begin
                if (pixCnt == pixTotalQ - PixW'(1)) begin
                    leave      = 1'b1;
                    enterState = StCksA;
                end else begin
                    loadNow  = 1'b1;
                    nextWord = byteSwap16(pixNext);
                    accEn    = 1'b1;
                    accDin   = pixNext;
                end
            end
            StCksA: if (xfer) begin
                leave      = 1'b1;
                enterState = StCksB;
            end
            StCksB: if (xfer) begin
                leave      = 1'b1;
                enterState = HasPad ? StPad : StDone;
            end
            StPad: if (xfer) begin
                if (padCnt == PadLast) begin
                    leave      = 1'b1;
                    enterState = StDone;
                end else begin
                    loadNow  = 1'b1;
                    nextWord = '0;
                end
            end
            default: nextState = StIdle;   // StDone lasts one cycle
        endcase

        if (leave) begin
            loadNow   = 1'b1;
            nextState = enterState;
            case (enterState)
                StHeader: begin
                    nextWord = header_word;
                    accEn    = 1'b1;
                    accDin   = byteSwap16(header_word);
                end
                StPixel: begin
                    nextWord = byteSwap16(curInit);
                    accEn    = 1'b1;
                    accDin   = curInit;
                end
                StCksA:  nextWord = sumSwapped[31:16] ^ {15'd0, curErr};
                StCksB:  nextWord = sumSwapped[15:0];
                default: nextWord = '0;    // pad words and the idle value
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            doutQ      <= '0;
            doutValidQ <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            header_idx <= '0;
            pixCnt     <= '0;
            pixTotalQ  <= '0;
            pixVal     <= '0;
            pixInitQ   <= '0;
            pixDeltaQ  <= '0;
            padCnt     <= '0;
        end else begin
            state <= nextState;
            done  <= 1'b0;
            if (loadNow)
                doutQ <= nextWord;
            if (idle && start) begin
                busy       <= 1'b1;
                doutValidQ <= 1'b1;
                pixInitQ   <= pixel_initial;
                pixDeltaQ  <= pixel_delta;
                pixTotalQ  <= PixW'(image_width) * PixW'(image_height);
                pixCnt     <= '0;
                padCnt     <= '0;
            end
            if (leave && (enterState == StDone)) begin
                busy       <= 1'b0;
                doutValidQ <= 1'b0;
                done       <= 1'b1;
            end
            if (loadNow && (nextState == StHeader))
                header_idx <= header_idx + 8'd1;
            else if (leave)
                header_idx <= '0;
            if (loadNow && (nextState == StPixel)) begin
                pixVal <= accDin;
                pixCnt <= (state == StPixel) ? pixCnt + PixW'(1) : '0;
            end
            if (loadNow && (nextState == StPad))
                padCnt <= (state == StPad) ? padCnt + 16'd1 : '0;
        end
    end

    test_image_generator_fletcher32_accum u_fletcher (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle && start),
        .en   (accEn),
        .din  (accDin),
        .dout (sum)
    );

    assign stream.dout       = doutQ;
    assign stream.dout_valid = doutValidQ;

endmodule

// File: tb/tb_test_image_generator.sv
// Bench for test_image_generator: two instances (with header/no pad, and no header/with pad)
// driven by the same config and ready pattern; expected streams from a reference model are
// queued per instance and popped by a monitor on every transfer.
module tb_test_image_generator;

    localparam int DW   = 12;
    localparam int HwcA = 5;
    localparam int PadA = 0;
    localparam int HwcB = 0;
    localparam int PadB = 2;

    logic          clk = 1'b0;
    logic          rst, start, errInj;
    logic [DW-1:0] imgW, imgH;
    logic [15:0]   pixInit, pixDelta;
    logic [7:0]    hdrIdxA, hdrIdxB;
    logic [15:0]   hdrWordA, hdrWordB;
    logic          busyA, busyB, doneA, doneB;
    int            readyMode;

    test_image_generator_if sA ();
    test_image_generator_if sB ();

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] expQ [2][$];
    logic [15:0] build [$];
    int          expLen [2];
    int          xfers [2];
    bit          armed [2];
    bit          gotDone [2];
    bit          stall [2];
    logic [15:0] stallDat [2];

    function automatic logic [15:0] hdrLookup(input logic [7:0] i);
        return {i ^ 8'h5A, i + 8'hC3};
    endfunction

    function automatic logic [15:0] swapBytes(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    assign hdrWordA = hdrLookup(hdrIdxA);
    assign hdrWordB = hdrLookup(hdrIdxB);

    test_image_generator #(.HeaderWordCount(HwcA), .PaddingWordCount(PadA), .DimWidth(DW)) dutA (
        .clk(clk), .rst(rst), .start(start),
        .image_width(imgW), .image_height(imgH),
        .pixel_initial(pixInit), .pixel_delta(pixDelta),
`ifdef TEST_IMAGE_GENERATOR_ERRINJ_EN
        .err_inject(errInj),
`endif
        .header_idx(hdrIdxA), .header_word(hdrWordA),
        .stream(sA), .busy(busyA), .done(doneA)
    );

    test_image_generator #(.HeaderWordCount(HwcB), .PaddingWordCount(PadB), .DimWidth(DW)) dutB (
        .clk(clk), .rst(rst), .start(start),
        .image_width(imgW), .image_height(imgH),
        .pixel_initial(pixInit), .pixel_delta(pixDelta),
`ifdef TEST_IMAGE_GENERATOR_ERRINJ_EN
        .err_inject(errInj),
`endif
        .header_idx(hdrIdxB), .header_word(hdrWordB),
        .stream(sB), .busy(busyB), .done(doneB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Reference stream: header words, pixel values init + p*delta, Fletcher-32 over
    // host values with plain modulo, checksum words low half first, then zero padding.
    task automatic buildStream(input int hwc, input int pad, input int w, input int h,
                               input logic [15:0] init, input logic [15:0] delta, input bit err);
        int          s1, s2;
        logic [15:0] host;
        build.delete();
        s1 = 0;
        s2 = 0;
        for (int k = 0; k < hwc; k++) begin
            build.push_back(hdrLookup(8'(k)));
            host = swapBytes(hdrLookup(8'(k)));
            s1 = (s1 + int'(host)) % 65535;
            s2 = (s2 + s1) % 65535;
        end
        for (int p = 0; p < w * h; p++) begin
            host = init + 16'(p) * delta;
            build.push_back(swapBytes(host));
            s1 = (s1 + int'(host)) % 65535;
            s2 = (s2 + s1) % 65535;
        end
        build.push_back(swapBytes(16'(s1)) ^ {15'd0, err});
        build.push_back(swapBytes(16'(s2)));
        for (int k = 0; k < pad; k++)
            build.push_back(16'h0000);
    endtask

    task automatic loadExp(input int id);
        expQ[id].delete();
        foreach (build[i]) expQ[id].push_back(build[i]);
        expLen[id]  = build.size();
        xfers[id]   = 0;
        gotDone[id] = 1'b0;
        armed[id]   = 1'b1;
    endtask

    task automatic observe(input int id, input logic vld, input logic rdy, input logic [15:0] dat,
                           input logic bsy, input logic dn);
        string tag;
        tag = (id == 0) ? "A" : "B";
        if (stall[id]) begin
            check({tag, "_stall_valid"}, 32'(vld), 32'd1);
            check({tag, "_stall_dout"}, 32'(dat), 32'(stallDat[id]));
        end
        if (vld && rdy) begin
            if (expQ[id].size() == 0)
                failNow($sformatf("%s_extra_word got 0x%0h, no word expected", tag, dat));
            else
                check($sformatf("%s_word%0d", tag, xfers[id]), 32'(dat), 32'(expQ[id].pop_front()));
            xfers[id]++;
        end
        stall[id]    = vld && !rdy;
        stallDat[id] = dat;
        if (dn) begin
            if (!armed[id])
                failNow($sformatf("%s_spurious_done got done=1, expected 0", tag));
            else begin
                check({tag, "_xfer_count"}, 32'(xfers[id]), 32'(expLen[id]));
                check({tag, "_valid_at_done"}, 32'(vld), 32'd0);
                check({tag, "_busy_at_done"}, 32'(bsy), 32'd0);
            end
            armed[id]   = 1'b0;
            gotDone[id] = 1'b1;
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall[0] = 1'b0;
                stall[1] = 1'b0;
            end else begin
                observe(0, sA.dout_valid, sA.dout_ready, sA.dout, busyA, doneA);
                observe(1, sB.dout_valid, sB.dout_ready, sB.dout, busyB, doneB);
            end
        end
    end

    // Sink ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random 75%
    initial begin
        logic r;
        r = 1'b1;
        sA.dout_ready = 1'b1;
        sB.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       r = ~r;
                2:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b1;
            endcase
            sA.dout_ready = r;
            sB.dout_ready = r;
        end
    end

    task automatic checkIdleOutputs(input string name);
        check({name, "_A_valid"}, 32'(sA.dout_valid), 32'd0);
        check({name, "_A_dout"},  32'(sA.dout), 32'd0);
        check({name, "_A_busy"},  32'(busyA), 32'd0);
        check({name, "_A_done"},  32'(doneA), 32'd0);
        check({name, "_A_hidx"},  32'(hdrIdxA), 32'd0);
        check({name, "_B_valid"}, 32'(sB.dout_valid), 32'd0);
        check({name, "_B_dout"},  32'(sB.dout), 32'd0);
        check({name, "_B_busy"},  32'(busyB), 32'd0);
        check({name, "_B_done"},  32'(doneB), 32'd0);
    endtask

    task automatic armCase(input string name, input int w, input int h, input logic [15:0] init,
                           input logic [15:0] delta, input bit err, input int mode);
        bit e;
        e = 1'b0;
`ifdef TEST_IMAGE_GENERATOR_ERRINJ_EN
        e = err;
`endif
        buildStream(HwcA, PadA, w, h, init, delta, e);
        loadExp(0);
        buildStream(HwcB, PadB, w, h, init, delta, e);
        loadExp(1);
        @(posedge clk);
        #1;
        imgW      = DW'(w);
        imgH      = DW'(h);
        pixInit   = init;
        pixDelta  = delta;
        errInj    = err;
        readyMode = mode;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_A_first_valid"}, 32'(sA.dout_valid), 32'd1);
        check({name, "_A_busy"}, 32'(busyA), 32'd1);
        check({name, "_B_first_valid"}, 32'(sB.dout_valid), 32'd1);
    endtask

    task automatic finishCase(input string name);
        for (int c = 0; c < 20000 && !(gotDone[0] && gotDone[1]); c++)
            @(negedge clk);
        if (!(gotDone[0] && gotDone[1]))
            failNow({name, "_timeout no done pulse within 20000 cycles"});
        check({name, "_A_left"}, 32'(expQ[0].size()), 32'd0);
        check({name, "_B_left"}, 32'(expQ[1].size()), 32'd0);
    endtask

    task automatic runCase(input string name, input int w, input int h, input logic [15:0] init,
                           input logic [15:0] delta, input bit err, input int mode);
        armCase(name, w, h, init, delta, err, mode);
        finishCase(name);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        errInj    = 1'b0;
        imgW      = '0;
        imgH      = '0;
        pixInit   = '0;
        pixDelta  = '0;
        readyMode = 0;
        armed[0]  = 1'b0;
        armed[1]  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;

        runCase("small",   2, 1, 16'h0001, 16'h0001, 1'b0, 0);
        runCase("toggle",  4, 3, 16'h1234, 16'h0101, 1'b0, 1);
        runCase("empty",   0, 0, 16'h5555, 16'h0003, 1'b0, 2);
        runCase("wrap",  300, 1, 16'h0000, 16'hFFFF, 1'b0, 2);
        for (int i = 0; i < 6; i++)
            runCase($sformatf("rnd%0d", i), $urandom_range(0, 9), $urandom_range(0, 9),
                    16'($urandom), 16'($urandom), 1'b0, $urandom_range(0, 2));

        // A second start while busy must not disturb the stream already queued;
        // then a reset in the pixel section aborts both instances silently.
        armCase("abort", 8, 8, 16'h0A0B, 16'h0003, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        imgW     = DW'(3);
        imgH     = DW'(2);
        pixInit  = 16'hFFFF;
        pixDelta = 16'h0100;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdleOutputs("midrst");
        expQ[0].delete();
        expQ[1].delete();
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        repeat (5) @(posedge clk);
        runCase("after_rst", 3, 3, 16'h00F0, 16'h0010, 1'b0, 2);

`ifdef TEST_IMAGE_GENERATOR_ERRINJ_EN
        runCase("errinj", 2, 1, 16'h0001, 16'h0001, 1'b1, 0);
        runCase("errinj_off", 2, 1, 16'h0001, 16'h0001, 1'b0, 1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
